// File: rtl/mvm_stream_pkg.sv
// Shared types and helpers for the streaming matrix-vector multiplier.
// Defining MVM_SATURATE_EN clamps results to the 2B signed range.
package mvm_stream_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, CALC, DRAIN} state_t;

  // Wide enough for an N-term sum of BxB products with no overflow.
  function automatic int calc_aw(input int b, input int n);
    return 2 * b + $clog2(n);
  endfunction

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mvm_lane.sv
// One MAC lane: owns R consecutive matrix rows, a copy of x and its row results.
// Result clamping is enabled by MVM_SATURATE_EN.
module mvm_lane
  import mvm_stream_pkg::*;
#(
  parameter int R  = 4,
  parameter int N  = 8,
  parameter int B  = 8,
  parameter int G  = 0,
  parameter int AW = 19,
  parameter int OW = 19,
  localparam int RW = (R > 1) ? $clog2(R) : 1,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m_we,
  input  logic [RW-1:0]        m_row,
  input  logic [CW-1:0]        m_col,
  input  logic                 x_we,
  input  logic [CW-1:0]        x_col,
  input  logic signed [B-1:0]  wdata,
  input  logic                 run,
  input  logic [RW-1:0]        y_addr,
  output logic signed [OW-1:0] y_data
);

  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [RW-1:0] R_LAST = RW'(R - 1);

  logic signed [B-1:0]  a_mem [R][N];
  logic signed [B-1:0]  x_mem [N];
  logic signed [OW-1:0] y_mem [R];

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic signed [2*B-1:0] prod;

  logic                  s_v, s_first, s_last;
  logic [RW-1:0]         s_row;
  logic signed [2*B-1:0] s_prod;

  logic signed [AW-1:0] acc, acc_base, acc_nx;
  logic signed [OW-1:0] y_val;

  always_ff @(posedge clk) begin
    if (m_we) a_mem[m_row][m_col] <= wdata;
    if (x_we) x_mem[x_col] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (run) begin
      if (col == C_LAST) begin
        col <= '0;
        row <= (row == R_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign prod = a_mem[row][col] * x_mem[col];

  generate
    if (G != 0) begin : g_pipe
      always_ff @(posedge clk) begin
        if (!reset) begin
          s_v     <= 1'b0;
          s_first <= 1'b0;
          s_last  <= 1'b0;
          s_row   <= '0;
          s_prod  <= '0;
        end else begin
          s_v     <= run;
          s_first <= (col == '0);
          s_last  <= (col == C_LAST);
          s_row   <= row;
          s_prod  <= prod;
        end
      end
    end else begin : g_comb
      assign s_v     = run;
      assign s_first = (col == '0);
      assign s_last  = (col == C_LAST);
      assign s_row   = row;
      assign s_prod  = prod;
    end
  endgenerate

  always_comb begin
    acc_base = s_first ? '0 : acc;
    acc_nx   = acc_base + AW'(s_prod);
`ifdef MVM_SATURATE_EN
    y_val = OW'(sat_clamp(64'(acc_nx), OW));
`else
    y_val = acc_nx;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) acc <= '0;
    else if (s_v) acc <= acc_nx;
  end

  always_ff @(posedge clk) begin
    if (s_v && s_last) y_mem[s_row] <= y_val;
  end

  assign y_data = y_mem[y_addr];

endmodule

// File: rtl/mvm_stream.sv
// Streaming y = A*x with P row-partitioned lanes; A is kept across vector reloads.
// state  | meaning
// IDLE   | waiting for ld_mat / ld_vec / start (start needs both operands loaded)
// LOAD_M | accepting M*N matrix beats, row-major
// LOAD_V | accepting N vector beats
// CALC   | lanes run N MACs per row for their M/P rows
// DRAIN  | results handed out in row order with backpressure
// Defining MVM_SATURATE_EN narrows out_data to 2B with clamping.
module mvm_stream
  import mvm_stream_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 8,
  parameter int P = 2,
  parameter int B = 8,
  parameter int G = 0,
  localparam int AW = calc_aw(B, N),
`ifdef MVM_SATURATE_EN
  localparam int OW = 2 * B
`else
  localparam int OW = calc_aw(B, N)
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_mat,
  input  logic                 ld_vec,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [B-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int R        = M / P;
  localparam int LW       = (P > 1) ? $clog2(P) : 1;
  localparam int RW       = (R > 1) ? $clog2(R) : 1;
  localparam int CW       = (N > 1) ? $clog2(N) : 1;
  localparam int CALC_LEN = R * N + G + 1;
  localparam int KW       = $clog2(CALC_LEN + 1);

  localparam logic [LW-1:0] L_LAST = LW'(P - 1);
  localparam logic [RW-1:0] R_LAST = RW'(R - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [KW-1:0] K_LAST = KW'(CALC_LEN - 1);
  localparam logic [KW-1:0] K_RUN  = KW'(R * N);

  state_t        state;
  logic          mat_ok, vec_ok;
  logic [LW-1:0] ld_lane, d_lane, nl;
  logic [RW-1:0] ld_row, d_row, nr;
  logic [CW-1:0] ld_col;
  logic [KW-1:0] cnt;
  logic          beat, run, last_nx;
  logic signed [OW-1:0] y_lane [P];
  logic signed [OW-1:0] y_sel;

  assign beat = in_valid && in_ready;
  assign run  = (state == CALC) && (cnt < K_RUN);

  // Look one result ahead while a result is on the port so handshakes can be back-to-back.
  always_comb begin
    nl = d_lane;
    nr = d_row;
    if (out_valid) begin
      if (d_row == R_LAST) begin
        nr = '0;
        nl = d_lane + 1'b1;
      end else begin
        nr = d_row + 1'b1;
      end
    end
  end

  assign last_nx = (nl == L_LAST) && (nr == R_LAST);
  assign y_sel   = y_lane[nl];

  for (genvar li = 0; li < P; li++) begin : g_lane
    mvm_lane #(.R(R), .N(N), .B(B), .G(G), .AW(AW), .OW(OW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .m_we  ((state == LOAD_M) && beat && (ld_lane == LW'(li))),
      .m_row (ld_row),
      .m_col (ld_col),
      .x_we  ((state == LOAD_V) && beat),
      .x_col (ld_col),
      .wdata (in_data),
      .run   (run),
      .y_addr(nr),
      .y_data(y_lane[li])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      mat_ok    <= 1'b0;
      vec_ok    <= 1'b0;
      ld_lane   <= '0;
      ld_row    <= '0;
      ld_col    <= '0;
      cnt       <= '0;
      d_lane    <= '0;
      d_row     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && mat_ok && vec_ok) begin
            state <= CALC;
            busy  <= 1'b1;
            cnt   <= '0;
          end else if (ld_mat) begin
            state    <= LOAD_M;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end else if (ld_vec) begin
            state    <= LOAD_V;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        LOAD_M: if (beat) begin
          if (ld_col == C_LAST) begin
            ld_col <= '0;
            if (ld_row == R_LAST) begin
              ld_row <= '0;
              if (ld_lane == L_LAST) begin
                ld_lane  <= '0;
                mat_ok   <= 1'b1;
                vec_ok   <= 1'b0;
                state    <= IDLE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
              end else begin
                ld_lane <= ld_lane + 1'b1;
              end
            end else begin
              ld_row <= ld_row + 1'b1;
            end
          end else begin
            ld_col <= ld_col + 1'b1;
          end
        end
        LOAD_V: if (beat) begin
          if (ld_col == C_LAST) begin
            ld_col   <= '0;
            vec_ok   <= 1'b1;
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else begin
            ld_col <= ld_col + 1'b1;
          end
        end
        CALC: begin
          if (cnt == K_LAST) begin
            state  <= DRAIN;
            cnt    <= '0;
            d_lane <= '0;
            d_row  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= y_sel;
            out_last  <= last_nx;
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
              busy      <= 1'b0;
              d_lane    <= '0;
              d_row     <= '0;
            end else begin
              d_lane   <= nl;
              d_row    <= nr;
              out_data <= y_sel;
              out_last <= last_nx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_stream.sv
// Directed plus randomized bench for mvm_stream at M=4, N=4, P=2, B=8,
// compared against a plain arithmetic model of y = A*x.
module tb_mvm_stream;

  localparam int M = 4;
  localparam int N = 4;
  localparam int P = 2;
  localparam int B = 8;
`ifdef MVM_SATURATE_EN
  localparam int OW  = 16;
  localparam bit SAT = 1'b1;
`else
  localparam int OW  = 18;
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ld_mat = 1'b0, ld_vec = 1'b0, start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [B-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [OW-1:0] out_data;
  logic out_last;
  logic busy;

  int checks = 0;
  int errors = 0;

  int     a_m [M][N];
  int     x_m [N];
  longint exp_y [M];
  int     beats [M*N];

  mvm_stream #(.M(M), .N(N), .P(P), .B(B), .G(0)) dut (
    .clk(clk), .reset(reset), .ld_mat(ld_mat), .ld_vec(ld_vec), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void compute();
    for (int r = 0; r < M; r++) begin
      longint s = 0;
      for (int c = 0; c < N; c++) s += longint'(a_m[r][c]) * longint'(x_m[c]);
      if (SAT && s > 32767) s = 32767;
      if (SAT && s < -32768) s = -32768;
      exp_y[r] = s;
    end
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic send(input string tag, input int n, input int vp);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 1000) begin
      bit v = ($urandom_range(0, 99) < vp);
      bit rdy = in_ready;
      in_valid = v;
      in_data = beats[idx][7:0];
      step();
      if (v && rdy) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check({tag, "_beats"}, idx, n);
    check({tag, "_ready_after"}, in_ready, 0);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic load_mat(input int vp);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) beats[r*N + c] = a_m[r][c];
    ld_mat = 1'b1;
    step();
    ld_mat = 1'b0;
    send("load_mat", M*N, vp);
  endtask

  task automatic load_vec(input int vp);
    for (int c = 0; c < N; c++) beats[c] = x_m[c];
    ld_vec = 1'b1;
    step();
    ld_vec = 1'b0;
    send("load_vec", N, vp);
  endtask

  task automatic run(input string tag, input int stall_row, input int stall_len,
                     input int rp, input bit with_ld);
    int k = 0, guard = 0, stall_cnt = 0;
    bit held = 0;
    longint hold_val = 0;
    logic hold_last = 0;
    compute();
    start = 1'b1;
    ld_mat = with_ld;
    step();
    start = 1'b0;
    ld_mat = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_not_loading"}, in_ready, 0);
    while (k < M && guard < 300) begin
      if (out_valid) begin
        if (held) begin
          check({tag, "_hold_data"}, out_data, hold_val);
          check({tag, "_hold_last"}, out_last, hold_last);
        end
        if (k == stall_row && stall_cnt < stall_len) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = ($urandom_range(0, 99) < rp);
        end
        if (out_ready) begin
          check($sformatf("%s_y%0d", tag, k), out_data, exp_y[k]);
          check($sformatf("%s_last%0d", tag, k), out_last, (k == M-1));
          k++;
          held = 0;
        end else begin
          held = 1;
          hold_val = out_data;
          hold_last = out_last;
        end
      end else begin
        if (held) check({tag, "_valid_dropped"}, out_valid, 1);
        held = 0;
        out_ready = $urandom_range(0, 1);
      end
      step();
      guard++;
    end
    out_ready = 1'b0;
    check({tag, "_count"}, k, M);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_valid_end"}, out_valid, 0);
  endtask

  initial begin
    reset = 1'b0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b1;

    // start with no operands loaded is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("nostart_busy", busy, 0);
    check("nostart_valid", out_valid, 0);

    // identity times [1,2,3,4], no backpressure
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) a_m[r][c] = (r == c) ? 1 : 0;
    for (int c = 0; c < N; c++) x_m[c] = c + 1;
    load_mat(100);
    load_vec(100);
    run("ident", -1, 0, 100, 1'b0);

    // same operands, row 1 stalled for 3 cycles
    run("stall", 1, 3, 100, 1'b0);

    // extreme negative operands
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) a_m[r][c] = -128;
    for (int c = 0; c < N; c++) x_m[c] = -128;
    load_mat(80);
    load_vec(80);
    run("neg", -1, 0, 100, 1'b0);

    // matrix retained across a vector-only reload
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) a_m[r][c] = rnd8();
    for (int c = 0; c < N; c++) x_m[c] = 1;
    load_mat(70);
    load_vec(70);
    run("x1", -1, 0, 70, 1'b0);
    x_m[0] = 2; x_m[1] = 0; x_m[2] = 0; x_m[3] = 0;
    load_vec(70);
    run("x2", -1, 0, 70, 1'b0);

    // start wins over a simultaneous ld_mat
    run("start_wins", -1, 0, 100, 1'b1);

    // randomized operands and handshakes
    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++) a_m[r][c] = rnd8();
      for (int c = 0; c < N; c++) x_m[c] = rnd8();
      load_mat(60);
      load_vec(60);
      run($sformatf("rand%0d", it), int'($urandom_range(0, M-1)), 2, 60, 1'b0);
    end

    // reset in the middle of CALC
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("midcalc_busy", busy, 1);
    reset = 1'b0;
    step();
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_out_data", out_data, 0);
    reset = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("postrst_start_busy", busy, 0);
    check("postrst_start_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvm_stream.md
Name: mvm_stream

Overview:
- Parametrised successor to the fixed-square matrix-vector multiplier.
- Computes y = A·x for a rectangular M×N signed matrix using P parallel MAC lanes.
- Operands are loaded over a valid/ready input stream; results are drained over a valid/ready output stream with backpressure.
- The matrix is retained across vector reloads, so repeated products reuse the stored A.

Parameters:
M, 8, matrix rows; must be a multiple of P
N, 8, matrix columns = vector length
P, 2, parallel MAC lanes; lane i owns rows i*(M/P) .. (i+1)*(M/P)-1
B, 8, signed operand width
G, 0, extra MAC pipeline register between multiplier and adder (0 or 1)
AW, 2*B+$clog2(N), accumulator width (derived localparam, not overridable)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
ld_mat  in  1  pulse: begin matrix load (M*N beats, row-major)
ld_vec  in  1  pulse: begin vector load (N beats)
start  in  1  pulse: begin computation
in_valid  in  1  input beat valid
in_ready  out  1  block accepts a beat
in_data  in  B  signed operand
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  OW  signed result; OW = 2*B with SATURATE_EN, AW without
out_last  out  1  asserted with row M-1 result
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; in_ready, out_valid, out_last, busy = 0; out_data = 0; mat_ok and vec_ok flags cleared; all counters = 0.
- States: IDLE, LOAD_M, LOAD_V, CALC, DRAIN.
- IDLE priority: start (only if mat_ok & vec_ok) > ld_mat > ld_vec. Otherwise stay in IDLE. A start without both flags set is ignored.
- LOAD_M: in_ready=1. Each in_valid&in_ready beat is written to the owning lane at (row%(M/P), col). After beat M*N-1: set mat_ok, clear vec_ok, go to IDLE.
- LOAD_V: in_ready=1. Beat c is written to x[c] of every lane. After beat N-1: set vec_ok, go to IDLE.
- ld_mat, ld_vec and start are ignored outside IDLE. in_ready=0 outside LOAD states.
- CALC: all lanes step row-by-row, N MACs per row, with the accumulator cleared at each row start. Each lane writes its row result to its y buffer.
  - CALC lasts exactly (M/P)*N + G + 1 cycles, then goes to DRAIN.
  - mat_ok and vec_ok stay set, so start may repeat.
- DRAIN: results are presented in row order 0..M-1.
  - out_data and out_last are held stable while out_valid & !out_ready.
  - Advance only on the handshake. After the row M-1 handshake: out_valid=0, go to IDLE.
- Arithmetic: product is 2B signed; accumulation is AW signed, with no overflow possible inside AW.
- Mid-operation reset: immediate return to reset values. Any partial load is discarded and both flags are cleared.

Optional Feature:
- Macro: MVM_SATURATE_EN.
- Defined: each AW result is clamped to the 2B signed range [-2^(2B-1), 2^(2B-1)-1] before storage into y; OW = 2*B.
- Undefined: full-precision result with no clamping; OW = AW.

Decomposition:
- Package mvm_stream_pkg:
  - state enum (IDLE, LOAD_M, LOAD_V, CALC, DRAIN)
  - a localparam function computing AW from B and N
  - a saturation function, parameterised by input and output width
- Sub-module mvm_lane, instanced P times. It contains:
  - a matrix RAM of (M/P)*N entries
  - an x RAM of N entries
  - the MAC, with optional G stage
  - a y buffer of M/P entries
  - row/column counters
- The top-level FSM, row multiplexer and handshake logic live in mvm_stream.

Test Plan:
- M=4, N=4, P=2, B=8. Load identity, load x=[1,2,3,4], start, out_ready=1 -> out_data 1,2,3,4 on consecutive handshakes; out_last only on 4; busy drops the cycle after.
- Same setup, out_ready low for 3 cycles while row 1 is presented -> out_data=2 stays stable for 3 cycles; no result skipped or duplicated.
- A and x all -128, N=4 -> each row 65536 without MVM_SATURATE_EN (AW=18); 32767 with it.
- Load A, load x1=[1,1,1,1], start, drain; then reload x2=[2,0,0,0] only and start -> results reflect the retained A times x2 (row r = 2*A[r][0]).
- start after reset with no loads -> ignored, busy=0, out_valid=0. Then ld_mat and start asserted together in IDLE with flags set -> CALC is entered (start wins).
- reset driven low during CALC -> next cycle all outputs 0, state IDLE. A subsequent start with no reload is ignored.
